// File: rtl/axis_pulse_limiter_if.sv
// AXI-Stream beat bundle (tdata/tvalid/tlast/tready) shared by the limiter ports and the bench.
// Latency: none, wires only.
// Backpressure: tready flows from the sink back to the source.
interface axis_pulse_limiter_if #(
    parameter int DATA_WIDTH = 16
) ();
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tlast;
    logic                  tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_pulse_limiter.sv
// Gain stage before the DAC: scales samples by a slewed gain, ramps to zero and latches a trip on overload.
// Latency: 2 cycles (multiply stage, round/saturate stage); build option PULSE_LIMITER_TLAST_REARM_EN re-arms on frame boundaries.
// Backpressure: one global enable; s_axis.tready = ~m_axis.tvalid | m_axis.tready, both stages hold when it is low.
module axis_pulse_limiter #(
    parameter int AXIS_TDATA_WIDTH = 16,
    parameter int GAIN_WIDTH       = 16,
    parameter int RAMP_WIDTH       = 16
) (
    input  logic                             aclk,
    input  logic                             areset,
    input  logic [GAIN_WIDTH+RAMP_WIDTH:0]   cfg_data,
    input  logic                             overload,
    output logic [31:0]                      sts_data,
    axis_pulse_limiter_if.slave              s_axis,
    axis_pulse_limiter_if.master             m_axis
);
    localparam int W  = AXIS_TDATA_WIDTH;
    localparam int G  = GAIN_WIDTH;
    localparam int R  = RAMP_WIDTH;
    localparam int PW = W + G + 1;
    localparam int CW = ((G > R) ? G : R) + 1;

    // Rounding constant: half an output LSB after the shift by G-1.
    localparam logic signed [PW-1:0] RND     = {{(PW-G+1){1'b0}}, 1'b1, {(G-2){1'b0}}};
    localparam logic [W-1:0]         OUT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]         OUT_MIN = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [PW-1:0] SAT_HI  = $signed({{(PW-W){1'b0}}, OUT_MAX});
    localparam logic signed [PW-1:0] SAT_LO  = $signed({{(PW-W){1'b1}}, OUT_MIN});

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DOWN    = 2'd1,
        ST_TRIPPED = 2'd2,
        ST_UP      = 2'd3
    } state_t;

    logic [G-1:0] gain_cfg;
    logic [R-1:0] ramp_step;
    logic         trip_clear;

    assign gain_cfg   = cfg_data[G-1:0];
    assign ramp_step  = cfg_data[G+R-1:G];
    assign trip_clear = cfg_data[G+R];

    state_t       state;
    logic [G-1:0] cur_gain;
    logic [7:0]   trip_cnt;
    logic         clear_q;
`ifdef PULSE_LIMITER_TLAST_REARM_EN
    logic         rearm_pending;
`endif

    logic         en;
    logic         accept;
    logic         clear_edge;
    logic [G-1:0] target;
    logic [G-1:0] next_gain;

    logic                 s1_vld;
    logic                 s1_last;
    logic signed [PW-1:0] s1_prod;
    logic signed [PW-1:0] prod_c;
    logic signed [PW-1:0] rnd_sum;
    logic signed [PW-1:0] shifted;
    logic [W-1:0]         sat_c;

    logic         out_vld;
    logic         out_last;
    logic [W-1:0] out_dat;

    assign en         = ~out_vld | m_axis.tready;
    assign accept     = s_axis.tvalid & en;
    assign clear_edge = trip_clear & ~clear_q;

    assign s_axis.tready = en;
    assign m_axis.tvalid = out_vld;
    assign m_axis.tdata  = out_dat;
    assign m_axis.tlast  = out_last;

    // Ramping down while tripping; otherwise follow the programmed gain.
    assign target = ((state == ST_RUN) || (state == ST_UP)) ? gain_cfg : '0;

    assign sts_data = {state, 6'b0, trip_cnt, 16'(cur_gain)};

    // Next gain one step toward target, landing exactly on it; step 0 jumps straight there.
    always_comb begin
        logic [CW-1:0] gain_x;
        logic [CW-1:0] tgt_x;
        logic [CW-1:0] step_x;
        gain_x    = CW'(cur_gain);
        tgt_x     = CW'(target);
        step_x    = CW'(ramp_step);
        next_gain = cur_gain;
        if (gain_x < tgt_x) begin
            if ((step_x == '0) || ((tgt_x - gain_x) <= step_x)) next_gain = target;
            else                                                 next_gain = G'(gain_x + step_x);
        end else if (gain_x > tgt_x) begin
            if ((step_x == '0) || ((gain_x - tgt_x) <= step_x)) next_gain = target;
            else                                                 next_gain = G'(gain_x - step_x);
        end
    end

    // Multiply with the gain as it stands in the acceptance cycle, then round half up and clamp.
    always_comb begin
        prod_c  = PW'($signed(s_axis.tdata)) * PW'($signed({1'b0, cur_gain}));
        rnd_sum = s1_prod + RND;
        shifted = rnd_sum >>> (G - 1);
        if (shifted > SAT_HI)      sat_c = OUT_MAX;
        else if (shifted < SAT_LO) sat_c = OUT_MIN;
        else                       sat_c = shifted[W-1:0];
    end

    // Two-stage datapath advancing on the global enable; reset flushes beats in flight.
    always_ff @(posedge aclk) begin
        if (areset) begin
            s1_vld   <= 1'b0;
            s1_last  <= 1'b0;
            s1_prod  <= '0;
            out_vld  <= 1'b0;
            out_last <= 1'b0;
            out_dat  <= '0;
        end else if (en) begin
            s1_vld   <= s_axis.tvalid;
            s1_last  <= s_axis.tlast;
            s1_prod  <= prod_c;
            out_vld  <= s1_vld;
            out_last <= s1_last;
            out_dat  <= sat_c;
        end
    end

    // Trip FSM, gain slew (only on accepted beats) and trip counter.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state    <= ST_UP;
            cur_gain <= '0;
            trip_cnt <= '0;
            clear_q  <= 1'b0;
`ifdef PULSE_LIMITER_TLAST_REARM_EN
            rearm_pending <= 1'b0;
`endif
        end else begin
            clear_q <= trip_clear;
            if (accept) cur_gain <= next_gain;
            case (state)
                ST_UP: begin
                    if (overload) begin
                        state    <= ST_DOWN;
                        trip_cnt <= (trip_cnt == 8'hFF) ? trip_cnt : trip_cnt + 8'd1;
                    end else if (cur_gain == target) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (overload) begin
                        state    <= ST_DOWN;
                        trip_cnt <= (trip_cnt == 8'hFF) ? trip_cnt : trip_cnt + 8'd1;
                    end
                end
                ST_DOWN: begin
                    if (cur_gain == '0) state <= ST_TRIPPED;
                end
                ST_TRIPPED: begin
`ifdef PULSE_LIMITER_TLAST_REARM_EN
                    // Overload cancels a pending re-arm; otherwise wait for the end of a frame.
                    if (overload) begin
                        rearm_pending <= 1'b0;
                    end else if (rearm_pending && accept && s_axis.tlast) begin
                        rearm_pending <= 1'b0;
                        state         <= ST_UP;
                    end else if (clear_edge) begin
                        rearm_pending <= 1'b1;
                    end
`else
                    if (clear_edge && !overload) state <= ST_UP;
`endif
                end
                default: state <= ST_UP;
            endcase
        end
    end
endmodule

// File: tb/tb_axis_pulse_limiter.sv
// Self-checking bench for axis_pulse_limiter: directed spec scenarios followed by a random soak.
// Latency: a reference model predicts every cycle's outputs and status from the behavioural rules.
// Backpressure: m_axis tready is driven by the bench, including random stalls.
module tb_axis_pulse_limiter;
    logic        aclk;
    logic        areset;
    logic        overload;
    logic [15:0] cfg_gain;
    logic [15:0] cfg_step;
    logic        cfg_clr;
    logic [32:0] cfg_data;
    logic [31:0] sts_data;

    axis_pulse_limiter_if #(.DATA_WIDTH(16)) s_if ();
    axis_pulse_limiter_if #(.DATA_WIDTH(16)) m_if ();

    assign cfg_data = {cfg_clr, cfg_step, cfg_gain};

    axis_pulse_limiter #(
        .AXIS_TDATA_WIDTH(16),
        .GAIN_WIDTH(16),
        .RAMP_WIDTH(16)
    ) dut (
        .aclk(aclk),
        .areset(areset),
        .cfg_data(cfg_data),
        .overload(overload),
        .sts_data(sts_data),
        .s_axis(s_if.slave),
        .m_axis(m_if.master)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: state codes RUN=0 DOWN=1 TRIPPED=2 UP=3, pipeline as two beat slots.
    int m_st = 3, m_gain = 0, m_cnt = 0;
    bit m_clr_q = 0, m_pend = 0, m_acc = 0;
    bit s1_v = 0, s2_v = 0, s1_l = 0, s2_l = 0;
    int s1_d = 0, s2_d = 0;
    int cap[$];
    bit cap_last[$];

    function automatic int scale(input int d, input int g);
        longint p;
        p = (longint'(d) * longint'(g) + 64'sd16384) >>> 15;
        if (p > 32767) p = 32767;
        if (p < -32768) p = -32768;
        return int'(p);
    endfunction

    function automatic int slew(input int g, input int t, input int step);
        if (g == t) return g;
        if (step == 0) return t;
        if (g < t) return (t - g <= step) ? t : g + step;
        return (g - t <= step) ? t : g - step;
    endfunction

    task automatic model_step();
        bit en_m, edge_c;
        int tgt, g_old;
        if (areset) begin
            m_st = 3; m_gain = 0; m_cnt = 0; m_clr_q = 0; m_pend = 0; m_acc = 0;
            s1_v = 0; s2_v = 0; s1_l = 0; s2_l = 0; s1_d = 0; s2_d = 0;
            return;
        end
        en_m   = !s2_v || m_if.tready;
        m_acc  = s_if.tvalid && en_m;
        g_old  = m_gain;
        tgt    = (m_st == 0 || m_st == 3) ? int'(cfg_gain) : 0;
        edge_c = cfg_clr && !m_clr_q;
        if (en_m) begin
            s2_v = s1_v; s2_d = s1_d; s2_l = s1_l;
            s1_v = s_if.tvalid; s1_d = scale(int'($signed(s_if.tdata)), g_old); s1_l = s_if.tlast;
        end
        if (m_acc) m_gain = slew(g_old, tgt, int'(cfg_step));
        if (m_st == 0 || m_st == 3) begin
            if (overload) begin
                m_st = 1;
                if (m_cnt < 255) m_cnt++;
            end else if (m_st == 3 && g_old == tgt) begin
                m_st = 0;
            end
        end else if (m_st == 1) begin
            if (g_old == 0) m_st = 2;
        end else begin
`ifdef PULSE_LIMITER_TLAST_REARM_EN
            if (overload) m_pend = 0;
            else if (m_pend && m_acc && s_if.tlast) begin m_pend = 0; m_st = 3; end
            else if (edge_c) m_pend = 1;
`else
            if (edge_c && !overload) m_st = 3;
`endif
        end
        m_clr_q = cfg_clr;
    endtask

    task automatic check_all();
        check("s_tready", s_if.tready, !s2_v || m_if.tready);
        check("m_tvalid", m_if.tvalid, s2_v);
        if (s2_v) begin
            check("m_tdata", $signed(m_if.tdata), s2_d);
            check("m_tlast", m_if.tlast, s2_l);
        end
        check("state", sts_data[31:30], m_st);
        check("trip_cnt", sts_data[23:16], m_cnt);
        check("cur_gain", sts_data[15:0], m_gain);
        if (m_if.tvalid && m_if.tready) begin
            cap.push_back(int'($signed(m_if.tdata)));
            cap_last.push_back(m_if.tlast);
        end
    endtask

    // One clock: compare at the falling edge, advance the model, return just after the rising edge.
    task automatic tick();
        @(negedge aclk);
        check_all();
        model_step();
        @(posedge aclk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        int sent, nz, pat[3];
        pat[0] = 20000; pat[1] = -20000; pat[2] = 1000;
        areset = 1; overload = 0; cfg_gain = 16'h4000; cfg_step = 16'h1000; cfg_clr = 0;
        s_if.tvalid = 0; s_if.tdata = '0; s_if.tlast = 0; m_if.tready = 1;
        ticks(3);
        check("rst_tvalid", m_if.tvalid, 0);
        check("rst_tdata", m_if.tdata, 0);
        check("rst_tlast", m_if.tlast, 0);
        check("rst_sts", sts_data, 32'hC000_0000);

        // Soft start
        areset = 0; cap.delete(); cap_last.delete();
        s_if.tvalid = 1; s_if.tdata = 16'd1000;
        ticks(2);
        check("soft_start_up", sts_data[31:30], 3);
        ticks(18);
        check("soft_start_n", cap.size() >= 6, 1);
        check("soft_start_0", cap[0], 0);
        check("soft_start_1", cap[1], 125);
        check("soft_start_2", cap[2], 250);
        check("soft_start_3", cap[3], 375);
        check("soft_start_4", cap[4], 500);
        check("soft_start_5", cap[5], 500);
        check("soft_start_run", sts_data[31:30], 0);

        // Saturation
        s_if.tvalid = 0; ticks(3);
        cap.delete(); cap_last.delete();
        cfg_gain = 16'hFFFF; cfg_step = 16'h0;
        for (int k = 0; k < 9; k++) begin
            s_if.tvalid = 1; s_if.tdata = 16'(pat[k % 3]);
            tick();
        end
        s_if.tvalid = 0; ticks(4);
        check("sat_count", cap.size(), 9);
        check("sat_pos", cap[3], 32767);
        check("sat_neg", cap[4], -32768);
        check("sat_gain2", cap[5], 2000);

        // Backpressure over one 16-beat frame at unity gain
        cfg_gain = 16'h8000; s_if.tvalid = 1; s_if.tdata = '0; ticks(2);
        s_if.tvalid = 0; ticks(4);
        cap.delete(); cap_last.delete();
        sent = 0;
        for (int tc = 0; tc < 60 && sent < 16; tc++) begin
            s_if.tvalid = 1; s_if.tdata = 16'(100 * sent - 700); s_if.tlast = (sent == 15);
            m_if.tready = !(tc >= 6 && tc < 11);
            tick();
            if (tc == 9) check("stall_s_tready", s_if.tready, 0);
            if (m_acc) sent++;
        end
        check("frame_sent", sent, 16);
        s_if.tvalid = 0; s_if.tlast = 0; m_if.tready = 1; ticks(6);
        check("frame_count", cap.size(), 16);
        for (int k = 0; k < cap.size() && k < 16; k++) begin
            check("frame_data", cap[k], 100 * k - 700);
            check("frame_last", cap_last[k], k == 15);
        end

        // Trip
        cfg_gain = 16'h4000; cfg_step = 16'h2000; s_if.tvalid = 1; s_if.tdata = 16'd1000;
        ticks(20);
        check("trip_pre_run", sts_data[31:30], 0);
        overload = 1; tick();
        overload = 0; tick();
        check("trip_gain_half", sts_data[15:0], 16'h2000);
        tick();
        check("trip_gain_zero", sts_data[15:0], 0);
        ticks(4);
        check("trip_state", sts_data[31:30], 2);
        check("trip_cnt_1", sts_data[23:16], 1);
        cap.delete(); cap_last.delete();
        ticks(6);
        nz = 0;
        foreach (cap[k]) if (cap[k] != 0) nz++;
        check("tripped_out_beats", cap.size() > 0, 1);
        check("tripped_out_nonzero", nz, 0);
        overload = 1; tick(); overload = 0; tick();
        check("trip_cnt_still_1", sts_data[23:16], 1);

        // Re-arm
        s_if.tlast = 1; cfg_clr = 1; ticks(2);
        check("rearm_up", sts_data[31:30], 3);
        ticks(12);
        check("rearm_gain", sts_data[15:0], 16'h4000);
        check("rearm_run", sts_data[31:30], 0);
        overload = 1; tick(); overload = 0; ticks(8);
        check("held_clear_no_rearm", sts_data[31:30], 2);
        check("trip_cnt_2", sts_data[23:16], 2);
        cfg_clr = 0; tick();
        cfg_clr = 1; overload = 1; tick(); overload = 0; ticks(5);
        check("clear_with_overload", sts_data[31:30], 2);
        cfg_clr = 0; tick();
        cfg_clr = 1; ticks(2);
        check("rearm_again", sts_data[31:30], 3);

        // Reset mid-ramp
        ticks(8);
        s_if.tvalid = 0; overload = 1; tick();
        overload = 0; s_if.tvalid = 1; tick();
        s_if.tvalid = 0; tick();
        check("pre_rst_state", sts_data[31:30], 1);
        check("pre_rst_gain", sts_data[15:0], 16'h2000);
        areset = 1; tick();
        check("rst_mid_tvalid", m_if.tvalid, 0);
        check("rst_mid_gain", sts_data[15:0], 0);
        check("rst_mid_cnt", sts_data[23:16], 0);
        check("rst_mid_state", sts_data[31:30], 3);
        areset = 0; cfg_clr = 0; s_if.tlast = 0;

        // Random soak against the model
        for (int c = 0; c < 3000; c++) begin
            if (c % 30 == 0) begin
                case ($urandom_range(0, 4))
                    0: cfg_gain = 16'h4000;
                    1: cfg_gain = 16'h8000;
                    2: cfg_gain = 16'hFFFF;
                    3: cfg_gain = 16'h0000;
                    default: cfg_gain = 16'($urandom);
                endcase
                cfg_step = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom_range(1, 16'h3000));
            end
            areset       = ($urandom_range(0, 699) == 0);
            overload     = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 14) == 0) cfg_clr = ~cfg_clr;
            s_if.tvalid  = ($urandom_range(0, 3) != 0);
            s_if.tdata   = 16'($urandom);
            s_if.tlast   = ($urandom_range(0, 7) == 0);
            m_if.tready  = ($urandom_range(0, 9) < 7);
            tick();
        end
        areset = 0; m_if.tready = 1; s_if.tvalid = 0;
        ticks(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
